// File: rtl/dac_pulse_seq.sv
// Staircase pulse-train sequencer feeding a serial DAC writer over a toggle request/ack handshake.
// Build option DAC_SEQ_SAT_EN: amplitude clamps at 0/255 instead of wrapping modulo 256.
module dac_pulse_seq #(
   parameter int HOLD_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              abort,
   input  logic [7:0]        v_start,
   input  logic [7:0]        v_step,
   input  logic              dir,
   input  logic [CNT_W-1:0]  n_pulses,
   input  logic [HOLD_W-1:0] hold_cycles,
   input  logic              dac_finish,
   output logic              dac_start,
   output logic [7:0]        pulse_h,
   output logic [CNT_W-1:0]  pulse_idx,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic              r_dac_start;
   logic [7:0]        r_pulse_h;
   logic [CNT_W-1:0]  r_pulse_idx;
   logic              r_busy;
   logic              r_done;
   logic              r_aborted;
   logic              r_abort_pend;
   logic [7:0]        r_v_step;
   logic              r_dir;
   logic [CNT_W-1:0]  r_n_pulses;
   logic [HOLD_W-1:0] r_hold_cycles;
   logic [HOLD_W-1:0] r_hold_cnt;

   logic              w_dac_start_next;
   logic [7:0]        w_pulse_h_next;
   logic [CNT_W-1:0]  w_pulse_idx_next;
   logic              w_busy_next;
   logic              w_done_next;
   logic              w_aborted_next;
   logic              w_abort_pend_next;
   logic [7:0]        w_v_step_next;
   logic              w_dir_next;
   logic [CNT_W-1:0]  w_n_pulses_next;
   logic [HOLD_W-1:0] w_hold_cycles_next;
   logic [HOLD_W-1:0] w_hold_cnt_next;

   logic              w_ack;
   logic              w_last;
   logic              w_abort_any;
   logic [8:0]        w_sum;
   logic [7:0]        w_amp_next;

   assign w_ack       = (dac_finish == r_dac_start);
   assign w_last      = (r_pulse_idx == (r_n_pulses - CNT_W'(1)));
   assign w_abort_any = r_abort_pend | abort;

   // Bit 8 of the 9-bit result flags carry (up) or borrow (down).
   assign w_sum = r_dir ? ({1'b0, r_pulse_h} - {1'b0, r_v_step})
                        : ({1'b0, r_pulse_h} + {1'b0, r_v_step});

`ifdef DAC_SEQ_SAT_EN
   assign w_amp_next = w_sum[8] ? (r_dir ? 8'h00 : 8'hFF) : w_sum[7:0];
`else
   assign w_amp_next = w_sum[7:0];
`endif

   always_comb begin
      w_state_next       = r_state;
      w_dac_start_next   = r_dac_start;
      w_pulse_h_next     = r_pulse_h;
      w_pulse_idx_next   = r_pulse_idx;
      w_busy_next        = r_busy;
      w_done_next        = 1'b0;
      w_aborted_next     = r_aborted;
      w_abort_pend_next  = r_abort_pend;
      w_v_step_next      = r_v_step;
      w_dir_next         = r_dir;
      w_n_pulses_next    = r_n_pulses;
      w_hold_cycles_next = r_hold_cycles;
      w_hold_cnt_next    = r_hold_cnt;

      case (r_state)
         S_IDLE: begin
            if (go) begin
               w_v_step_next      = v_step;
               w_dir_next         = dir;
               w_n_pulses_next    = n_pulses;
               w_hold_cycles_next = hold_cycles;
               w_aborted_next     = 1'b0;
               w_abort_pend_next  = 1'b0;
               w_pulse_idx_next   = '0;
               if (n_pulses == '0) begin
                  w_done_next  = 1'b1;
                  w_state_next = S_DONE;
               end else begin
                  w_pulse_h_next = v_start;
                  w_busy_next    = 1'b1;
                  w_state_next   = S_REQ;
               end
            end
         end

         S_REQ: begin
            w_dac_start_next = ~r_dac_start;
            if (abort) begin
               w_abort_pend_next = 1'b1;
            end
            w_state_next = S_WAIT;
         end

         // The frame in flight always completes; abort only takes effect on its ack.
         S_WAIT: begin
            if (abort) begin
               w_abort_pend_next = 1'b1;
            end
            if (w_ack) begin
               if (w_last || w_abort_any) begin
                  w_done_next    = 1'b1;
                  w_busy_next    = 1'b0;
                  w_aborted_next = w_abort_any & ~w_last;
                  w_state_next   = S_DONE;
               end else begin
                  w_hold_cnt_next = r_hold_cycles;
                  w_state_next    = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            if (w_abort_any) begin
               w_done_next    = 1'b1;
               w_busy_next    = 1'b0;
               w_aborted_next = 1'b1;
               w_state_next   = S_DONE;
            end else if (r_hold_cnt != '0) begin
               w_hold_cnt_next = r_hold_cnt - HOLD_W'(1);
            end else begin
               w_pulse_h_next   = w_amp_next;
               w_pulse_idx_next = r_pulse_idx + CNT_W'(1);
               w_state_next     = S_REQ;
            end
         end

         S_DONE: begin
            w_abort_pend_next = 1'b0;
            w_state_next      = S_IDLE;
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_dac_start   <= 1'b0;
         r_pulse_h     <= '0;
         r_pulse_idx   <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
         r_abort_pend  <= 1'b0;
         r_v_step      <= '0;
         r_dir         <= 1'b0;
         r_n_pulses    <= '0;
         r_hold_cycles <= '0;
         r_hold_cnt    <= '0;
      end else begin
         r_state       <= w_state_next;
         r_dac_start   <= w_dac_start_next;
         r_pulse_h     <= w_pulse_h_next;
         r_pulse_idx   <= w_pulse_idx_next;
         r_busy        <= w_busy_next;
         r_done        <= w_done_next;
         r_aborted     <= w_aborted_next;
         r_abort_pend  <= w_abort_pend_next;
         r_v_step      <= w_v_step_next;
         r_dir         <= w_dir_next;
         r_n_pulses    <= w_n_pulses_next;
         r_hold_cycles <= w_hold_cycles_next;
         r_hold_cnt    <= w_hold_cnt_next;
      end
   end

   assign dac_start = r_dac_start;
   assign pulse_h   = r_pulse_h;
   assign pulse_idx = r_pulse_idx;
   assign busy      = r_busy;
   assign done      = r_done;
   assign aborted   = r_aborted;

endmodule
